fetch_prefetch_buf: RTL

Parametrised instruction prefetch buffer for the Y86-64 pipeline. It replaces the flat combinational 10-byte read from a local instruction array.
- Fetches FETCH_BYTES-wide beats from an external instruction memory over a request/grant/response handshake.
- Stores the bytes in a byte ring buffer.
- Presents a 10-byte, PC-aligned window to the fetch split/align logic.
- Redirects (branch mispredict, ret, predicted target) flush the buffer and restart fetch. Out-of-range fetches are reported as a sticky address error.

---
 rtl/fetch_pkg.sv | 39 +++
 rtl/fetch_byte_ring.sv | 51 +++++
 rtl/fetch_prefetch_buf.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions for the Y86-64 pipeline.
//   MAX_INSTR_BYTES : longest Y86-64 instruction, i.e. the width of the fetch window
//   stat_e          : architectural status codes
//   I*              : icode values shared with decode
//   clog2           : ceiling log2 for sizing pointers and counters
package fetch_pkg;

    localparam int unsigned MAX_INSTR_BYTES = 10;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_byte_ring.sv
// Byte ring buffer for the instruction prefetcher.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push FETCH_BYTES bytes from wr_data at wr_ptr (lowest byte in [7:0])
//   wr_ptr     : ring index of the first pushed byte
//   rd_ptr     : ring index of window byte 0
//   count      : number of valid bytes starting at rd_ptr
//   window     : 10-byte read window, byte at rd_ptr in the top byte lane;
//                lanes at or beyond count read as zero
module fetch_byte_ring
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FETCH_BYTES = 4,
    localparam int unsigned PTR_W      = clog2(DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [PTR_W-1:0]               wr_ptr,
    input  logic [8*FETCH_BYTES-1:0]       wr_data,
    input  logic [PTR_W-1:0]               rd_ptr,
    input  logic [CNT_W-1:0]               count,
    output logic [8*MAX_INSTR_BYTES-1:0]   window
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(FETCH_BYTES); b++) begin
                mem_q[wr_ptr + PTR_W'(b)] <= wr_data[8*b +: 8];
            end
        end
    end

    // Pointer arithmetic is PTR_W bits wide, so the window wraps over the ring end for free.
    always_comb begin
        window = '0;
        for (int unsigned i = 0; i < MAX_INSTR_BYTES; i++) begin
            if (CNT_W'(i) < count) begin
                window[8*(MAX_INSTR_BYTES-1-i) +: 8] = mem_q[rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch buffer: fetches FETCH_BYTES-wide beats over a req/gnt/rvalid
// handshake, buffers them in a byte ring and presents a 10-byte PC-aligned window.
//   clk, rst_n            : clock, asynchronous active-low reset
//   redirect_valid_i/pc_i : flush buffer and restart fetch at redirect_pc_i
//   imem_req_o/addr_o     : beat request and its byte address
//   imem_gnt_i            : request accepted
//   imem_rvalid_i/rdata_i : response beat, lowest address in [7:0]
//   imem_err_i            : response is an address error
//   instr_valid_o         : window holds >= 10 bytes or an error is pending
//   instr_pc_o            : PC of window byte 0
//   instr_bytes_o         : window, byte at instr_pc_o in [79:72]
//   instr_err_o           : window truncated by a memory error
//   consume_i/len_i       : retire consume_len_i (1..10) bytes from the head
module fetch_prefetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter int unsigned       FETCH_BYTES = 4,
    parameter int unsigned       DEPTH       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    output logic                         imem_req_o,
    output logic [ADDR_W-1:0]            imem_addr_o,
    input  logic                         imem_gnt_i,
    input  logic                         imem_rvalid_i,
    input  logic [8*FETCH_BYTES-1:0]     imem_rdata_i,
    input  logic                         imem_err_i,
    output logic                         instr_valid_o,
    output logic [ADDR_W-1:0]            instr_pc_o,
    output logic [8*MAX_INSTR_BYTES-1:0] instr_bytes_o,
    output logic                         instr_err_o,
    input  logic                         consume_i,
    input  logic [3:0]                   consume_len_i
);

    localparam int unsigned       PTR_W   = clog2(DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  FB_C    = CNT_W'(FETCH_BYTES);
    localparam logic [CNT_W-1:0]  WIN_C   = CNT_W'(MAX_INSTR_BYTES);
    localparam logic [ADDR_W-1:0] FB_A    = ADDR_W'(FETCH_BYTES);

    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [ADDR_W-1:0] fetch_addr_q, head_pc_q;
    logic              outstanding_q, drop_q, err_q, run_q;

    logic              space_ok, rsp_fire, rsp_write, consume_fire;
    logic [CNT_W-1:0]  consume_amt, push_amt;

    // Space is judged on the pre-consume count; a same-cycle consume only frees room later.
    assign space_ok     = (DEPTH_C - count_q) >= FB_C;
    assign imem_req_o   = run_q & ~outstanding_q & ~err_q & ~redirect_valid_i & space_ok;
    assign imem_addr_o  = fetch_addr_q;

    // A response is only meaningful while a beat is outstanding; anything else
    // (e.g. a late beat from before a reset) is ignored.
    assign rsp_fire     = imem_rvalid_i & outstanding_q;
    assign rsp_write    = rsp_fire & ~drop_q & ~imem_err_i & ~redirect_valid_i;

    assign instr_valid_o = (count_q >= WIN_C) | err_q;
    assign instr_err_o   = err_q & (count_q < WIN_C);
    assign instr_pc_o    = head_pc_q;

    assign consume_fire = consume_i & instr_valid_o & ~redirect_valid_i;
    assign consume_amt  = consume_fire ? CNT_W'(consume_len_i) : '0;
    assign push_amt     = rsp_write ? FB_C : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fetch_addr_q  <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid_i) begin
                count_q      <= '0;
                rd_ptr_q     <= wr_ptr_q;
                head_pc_q    <= redirect_pc_i;
                fetch_addr_q <= redirect_pc_i;
                err_q        <= 1'b0;
                // A beat still in flight belongs to the old stream: mark it for discard.
                if (outstanding_q && !imem_rvalid_i) begin
                    drop_q <= 1'b1;
                end else begin
                    drop_q        <= 1'b0;
                    outstanding_q <= 1'b0;
                end
            end else begin
                count_q <= count_q - consume_amt + push_amt;
                if (consume_fire) begin
                    rd_ptr_q  <= rd_ptr_q + PTR_W'(consume_len_i);
                    head_pc_q <= head_pc_q + ADDR_W'(consume_len_i);
                end
                if (rsp_write) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(FETCH_BYTES);
                end
                if (rsp_fire) begin
                    outstanding_q <= 1'b0;
                    drop_q        <= 1'b0;
                    if (!drop_q && imem_err_i) begin
                        err_q <= 1'b1;
                    end
                end
                // Never coincides with rsp_fire: a request needs outstanding_q clear.
                if (imem_req_o && imem_gnt_i) begin
                    outstanding_q <= 1'b1;
                    fetch_addr_q  <= fetch_addr_q + FB_A;
                end
            end
        end
    end

    fetch_byte_ring #(
        .DEPTH       (DEPTH),
        .FETCH_BYTES (FETCH_BYTES)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rsp_write),
        .wr_ptr  (wr_ptr_q),
        .wr_data (imem_rdata_i),
        .rd_ptr  (rd_ptr_q),
        .count   (count_q),
        .window  (instr_bytes_o)
    );

endmodule
